// File: rtl/phase_sweep_pkg.sv
// Shared definitions for the phase sweep controller: state encoding,
// sweep counter width and a saturating increment helper.
package phase_sweep_pkg;

  localparam logic [2:0] ST_IDLE_CODE    = 3'd0;
  localparam logic [2:0] ST_SETTLE_CODE  = 3'd1;
  localparam logic [2:0] ST_MEASURE_CODE = 3'd2;
  localparam logic [2:0] ST_EVAL_CODE    = 3'd3;
  localparam logic [2:0] ST_LOCKED_CODE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = ST_IDLE_CODE,
    ST_SETTLE  = ST_SETTLE_CODE,
    ST_MEASURE = ST_MEASURE_CODE,
    ST_EVAL    = ST_EVAL_CODE,
    ST_LOCKED  = ST_LOCKED_CODE
  } state_t;

  localparam int SWEEP_CNT_W = 8;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [SWEEP_CNT_W-1:0] sat_inc(input logic [SWEEP_CNT_W-1:0] value);
    if (value == {SWEEP_CNT_W{1'b1}}) begin
      return value;
    end
    return value + 1'b1;
  endfunction

endpackage

// File: rtl/ber_window_counter.sv
// Counts compared bits and bit errors over a window of WINDOW valid bits.
// window_done is a combinational pulse on the valid bit that completes the
// window, and window_err already includes that bit, so the caller can act in
// the same cycle. The counter restarts by itself after each window.
module ber_window_counter #(
  parameter int WINDOW   = 1024,
  parameter int NB_COUNT = 11
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                bit_valid,
  input  logic                bit_error,
  output logic                window_done,
  output logic [NB_COUNT-1:0] window_err
);

  logic [NB_COUNT-1:0] bit_cnt_reg;
  logic [NB_COUNT-1:0] err_cnt_reg;
  logic [NB_COUNT-1:0] err_inc;

  assign err_inc     = {{(NB_COUNT-1){1'b0}}, bit_valid & bit_error};
  assign window_done = bit_valid && (bit_cnt_reg == NB_COUNT'(WINDOW - 1));
  assign window_err  = err_cnt_reg + err_inc;

  // Bit and error accumulation; a finished window starts the next from zero.
  always_ff @(posedge clock) begin
    if (reset || clear || window_done) begin
      bit_cnt_reg <= '0;
      err_cnt_reg <= '0;
    end else if (bit_valid) begin
      bit_cnt_reg <= bit_cnt_reg + 1'b1;
      err_cnt_reg <= err_cnt_reg + err_inc;
    end
  end

endmodule

// File: rtl/phase_sweep_ctrl.sv
// Link bring-up controller: enables tx/rx, sweeps the rx downsampling phase,
// measures bit errors per phase, locks on the best phase and re-sweeps when
// the locked phase degrades.
module phase_sweep_ctrl
  import phase_sweep_pkg::*;
#(
  parameter int OS         = 4,
  parameter int NB_PHASE   = 2,
  parameter int WINDOW     = 1024,
  parameter int SETTLE     = 64,
  parameter int MAX_ERRORS = 4,
  parameter int NB_COUNT   = 11
) (
  input  logic                   clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic                   i_bit_valid,
  input  logic                   i_bit_error,
  output logic                   o_tx_enable,
  output logic                   o_rx_enable,
  output logic [NB_PHASE-1:0]    o_phase,
  output logic                   o_ber_clear,
  output logic                   o_locked,
  output logic [NB_COUNT-1:0]    o_best_errors,
  output logic [SWEEP_CNT_W-1:0] o_sweep_count
);

  localparam int NB_SETTLE = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [NB_SETTLE-1:0] SETTLE_LAST = NB_SETTLE'(SETTLE - 1);
  localparam logic [NB_PHASE-1:0]  LAST_PHASE  = NB_PHASE'(OS - 1);
  localparam logic [NB_COUNT-1:0]  ERR_LIMIT   = NB_COUNT'(MAX_ERRORS);
  // "Nothing measured yet": any real window count beats it.
  localparam logic [NB_COUNT-1:0]  ERR_NONE    = {NB_COUNT{1'b1}};

  state_t                 state_reg, state_next;
  logic [NB_SETTLE-1:0]   settle_cnt_reg, settle_cnt_next;
  logic                   post_lock_reg, post_lock_next;
  logic [NB_PHASE-1:0]    phase_reg, phase_next;
  logic [NB_COUNT-1:0]    best_err_reg, best_err_next;
  logic [NB_PHASE-1:0]    best_phase_reg, best_phase_next;
  logic [NB_COUNT-1:0]    win_err_reg, win_err_next;
  logic                   tx_en_reg, tx_en_next;
  logic                   rx_en_reg, rx_en_next;
  logic                   ber_clear_reg, ber_clear_next;
  logic                   locked_reg, locked_next;
  logic [NB_COUNT-1:0]    best_errors_reg, best_errors_next;
  logic [SWEEP_CNT_W-1:0] sweep_cnt_reg, sweep_cnt_next;

  logic                   counting;
  logic                   window_done;
  logic [NB_COUNT-1:0]    window_err;
  logic                   eval_better;
  logic [NB_COUNT-1:0]    eval_best_err;
  logic [NB_PHASE-1:0]    eval_best_phase;

  // Bits only count while measuring a sweep phase or monitoring a lock.
  assign counting = (state_reg == ST_MEASURE) || (state_reg == ST_LOCKED);

  ber_window_counter #(
    .WINDOW   (WINDOW),
    .NB_COUNT (NB_COUNT)
  ) u_window (
    .clock       (clock),
    .reset       (i_reset),
    .clear       (~counting),
    .bit_valid   (i_bit_valid & counting),
    .bit_error   (i_bit_error),
    .window_done (window_done),
    .window_err  (window_err)
  );

  // Strict compare: on a tie the earlier (lower) phase stays the best.
  assign eval_better     = (win_err_reg < best_err_reg);
  assign eval_best_err   = eval_better ? win_err_reg : best_err_reg;
  assign eval_best_phase = eval_better ? phase_reg : best_phase_reg;

  // Next-state and next-output decisions for the whole controller.
  always_comb begin
    state_next       = state_reg;
    settle_cnt_next  = settle_cnt_reg;
    post_lock_next   = post_lock_reg;
    phase_next       = phase_reg;
    best_err_next    = best_err_reg;
    best_phase_next  = best_phase_reg;
    win_err_next     = win_err_reg;
    tx_en_next       = tx_en_reg;
    rx_en_next       = rx_en_reg;
    ber_clear_next   = 1'b0;
    locked_next      = locked_reg;
    best_errors_next = best_errors_reg;
    sweep_cnt_next   = sweep_cnt_reg;

    if (i_stop && (state_reg != ST_IDLE)) begin
      state_next     = ST_IDLE;
      tx_en_next     = 1'b0;
      rx_en_next     = 1'b0;
      locked_next    = 1'b0;
      post_lock_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_start && !i_stop) begin
            state_next      = ST_SETTLE;
            settle_cnt_next = '0;
            post_lock_next  = 1'b0;
            tx_en_next      = 1'b1;
            rx_en_next      = 1'b1;
            phase_next      = '0;
            best_err_next   = ERR_NONE;
            best_phase_next = '0;
            ber_clear_next  = 1'b1;
          end
        end

        ST_SETTLE: begin
          settle_cnt_next = settle_cnt_reg + 1'b1;
          if (settle_cnt_reg == SETTLE_LAST) begin
            settle_cnt_next = '0;
            if (post_lock_reg) begin
              state_next     = ST_LOCKED;
              locked_next    = 1'b1;
              post_lock_next = 1'b0;
            end else begin
              state_next = ST_MEASURE;
            end
          end
        end

        ST_MEASURE: begin
          if (window_done) begin
            state_next   = ST_EVAL;
            win_err_next = window_err;
          end
        end

        ST_EVAL: begin
          state_next      = ST_SETTLE;
          settle_cnt_next = '0;
          ber_clear_next  = 1'b1;
          best_err_next   = eval_best_err;
          best_phase_next = eval_best_phase;
          if (phase_reg < LAST_PHASE) begin
            phase_next = phase_reg + 1'b1;
          end else begin
            sweep_cnt_next   = sat_inc(sweep_cnt_reg);
            best_errors_next = eval_best_err;
            if (eval_best_err <= ERR_LIMIT) begin
              phase_next     = eval_best_phase;
              post_lock_next = 1'b1;
            end else begin
              phase_next      = '0;
              best_err_next   = ERR_NONE;
              best_phase_next = '0;
            end
          end
        end

        ST_LOCKED: begin
          if (window_done && (window_err > ERR_LIMIT)) begin
            state_next      = ST_SETTLE;
            settle_cnt_next = '0;
            locked_next     = 1'b0;
            phase_next      = '0;
            best_err_next   = ERR_NONE;
            best_phase_next = '0;
            ber_clear_next  = 1'b1;
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state, settle timer and post-lock flag.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_reg      <= ST_IDLE;
      settle_cnt_reg <= '0;
      post_lock_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      settle_cnt_reg <= settle_cnt_next;
      post_lock_reg  <= post_lock_next;
    end
  end

  // Current phase, best-so-far tracking and the captured window error count.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      phase_reg      <= '0;
      best_err_reg   <= ERR_NONE;
      best_phase_reg <= '0;
      win_err_reg    <= '0;
    end else begin
      phase_reg      <= phase_next;
      best_err_reg   <= best_err_next;
      best_phase_reg <= best_phase_next;
      win_err_reg    <= win_err_next;
    end
  end

  // Registered status and control outputs.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      tx_en_reg       <= 1'b0;
      rx_en_reg       <= 1'b0;
      ber_clear_reg   <= 1'b0;
      locked_reg      <= 1'b0;
      best_errors_reg <= ERR_NONE;
      sweep_cnt_reg   <= '0;
    end else begin
      tx_en_reg       <= tx_en_next;
      rx_en_reg       <= rx_en_next;
      ber_clear_reg   <= ber_clear_next;
      locked_reg      <= locked_next;
      best_errors_reg <= best_errors_next;
      sweep_cnt_reg   <= sweep_cnt_next;
    end
  end

  assign o_tx_enable   = tx_en_reg;
  assign o_rx_enable   = rx_en_reg;
  assign o_phase       = phase_reg;
  assign o_ber_clear   = ber_clear_reg;
  assign o_locked      = locked_reg;
  assign o_best_errors = best_errors_reg;
  assign o_sweep_count = sweep_cnt_reg;

endmodule

// File: tb/tb_phase_sweep_ctrl.sv
// Self-checking bench for phase_sweep_ctrl: drives whole sweeps with chosen or
// random per-phase error counts and compares against a per-sweep model
// (minimum error count, lowest phase on ties, lock threshold).
module tb_phase_sweep_ctrl;

  localparam int OS         = 4;
  localparam int NB_PHASE   = 2;
  localparam int WINDOW     = 16;
  localparam int SETTLE     = 8;
  localparam int MAX_ERRORS = 2;
  localparam int NB_COUNT   = 5;
  localparam int ERR_NONE   = 31;

  logic                clock = 1'b0;
  logic                i_reset = 1'b1;
  logic                i_start = 1'b0;
  logic                i_stop = 1'b0;
  logic                i_bit_valid = 1'b0;
  logic                i_bit_error = 1'b0;
  logic                o_tx_enable;
  logic                o_rx_enable;
  logic [NB_PHASE-1:0] o_phase;
  logic                o_ber_clear;
  logic                o_locked;
  logic [NB_COUNT-1:0] o_best_errors;
  logic [7:0]          o_sweep_count;

  int checks = 0;
  int errors = 0;

  // Model state carried between scenarios.
  int exp_sweeps = 0;
  int exp_best   = ERR_NONE;
  int lock_phase = 0;

  logic                obs_pulse [OS];
  logic [NB_PHASE-1:0] obs_phase [OS];
  int                  pat [OS];
  bit                  was_locked;

  phase_sweep_ctrl #(
    .OS         (OS),
    .NB_PHASE   (NB_PHASE),
    .WINDOW     (WINDOW),
    .SETTLE     (SETTLE),
    .MAX_ERRORS (MAX_ERRORS),
    .NB_COUNT   (NB_COUNT)
  ) dut (
    .clock         (clock),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_stop        (i_stop),
    .i_bit_valid   (i_bit_valid),
    .i_bit_error   (i_bit_error),
    .o_tx_enable   (o_tx_enable),
    .o_rx_enable   (o_rx_enable),
    .o_phase       (o_phase),
    .o_ber_clear   (o_ber_clear),
    .o_locked      (o_locked),
    .o_best_errors (o_best_errors),
    .o_sweep_count (o_sweep_count)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Advance one cycle; outputs are stable 1 time unit after the edge.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bits();
    i_bit_valid = 1'b0;
    i_bit_error = 1'b0;
  endtask

  // Expected outcome of one sweep: lowest error count, first phase wins ties.
  function automatic void model_sweep(input int errs [OS], output int best,
                                      output int bphase, output bit lock);
    best   = ERR_NONE;
    bphase = 0;
    for (int i = 0; i < OS; i++) begin
      if (errs[i] < best) begin
        best   = errs[i];
        bphase = i;
      end
    end
    lock = (best <= MAX_ERRORS);
  endfunction

  // From the first settle cycle: SETTLE cycles of junk (all errors), which
  // must be ignored, ending at the first post-settle cycle.
  task automatic settle_phase();
    repeat (SETTLE) begin
      i_bit_valid = 1'($urandom_range(1, 0));
      i_bit_error = 1'b1;
      next_cycle();
    end
    idle_bits();
  endtask

  // WINDOW valid bits with nerr errors at random positions and random gaps.
  // Returns in the cycle carrying the last valid bit.
  task automatic send_window(input int nerr);
    logic flags [WINDOW];
    logic tmp;
    int   j;
    int   sent;
    for (int i = 0; i < WINDOW; i++) flags[i] = (i < nerr);
    for (int i = WINDOW - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = flags[i];
      flags[i] = flags[j];
      flags[j] = tmp;
    end
    sent = 0;
    while (sent < WINDOW) begin
      if ($urandom_range(3, 0) == 0) begin
        i_bit_valid = 1'b0;
        i_bit_error = 1'($urandom_range(1, 0));
      end else begin
        i_bit_valid = 1'b1;
        i_bit_error = flags[sent];
        sent++;
      end
      if (sent < WINDOW) next_cycle();
    end
  endtask

  // Drive one full sweep starting at a phase-0 settle pulse; records the
  // pulse and phase seen at each phase start. Ends at the post-sweep pulse.
  task automatic sweep_phases(input int errs [OS]);
    for (int i = 0; i < OS; i++) begin
      obs_pulse[i] = o_ber_clear;
      obs_phase[i] = o_phase;
      settle_phase();
      send_window(errs[i]);
      next_cycle();
      idle_bits();
      next_cycle();
    end
  endtask

  task automatic start_sweep();
    i_start = 1'b1;
    next_cycle();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    idle_bits();
    repeat (3) next_cycle();
    checks++; if (o_tx_enable !== 1'b0) begin errors++; $display("FAIL reset_tx: got %b want 0", o_tx_enable); end
    checks++; if (o_rx_enable !== 1'b0) begin errors++; $display("FAIL reset_rx: got %b want 0", o_rx_enable); end
    checks++; if (o_phase !== '0) begin errors++; $display("FAIL reset_phase: got %0d want 0", o_phase); end
    checks++; if (o_ber_clear !== 1'b0) begin errors++; $display("FAIL reset_ber_clear: got %b want 0", o_ber_clear); end
    checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", o_locked); end
    checks++; if (o_best_errors !== NB_COUNT'(ERR_NONE)) begin errors++; $display("FAIL reset_best: got %0d want %0d", o_best_errors, ERR_NONE); end
    checks++; if (o_sweep_count !== 8'd0) begin errors++; $display("FAIL reset_sweeps: got %0d want 0", o_sweep_count); end
    i_reset = 1'b0;
    repeat (2) next_cycle();
    checks++;
    if (o_tx_enable !== 1'b0 || o_ber_clear !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: tx=%b ber_clear=%b want 0 0", o_tx_enable, o_ber_clear);
    end
    $display("reset: outputs checked");
  endtask

  // One full sweep from a phase-0 pulse, checked against the sweep model.
  task automatic test_sweep(input string name, input int errs [OS], output bit locked_out);
    int best, bphase;
    bit lock;
    model_sweep(errs, best, bphase, lock);
    checks++;
    if (o_tx_enable !== 1'b1 || o_rx_enable !== 1'b1) begin
      errors++; $display("FAIL %s_enables: tx=%b rx=%b want 1 1", name, o_tx_enable, o_rx_enable);
    end
    sweep_phases(errs);
    for (int i = 0; i < OS; i++) begin
      checks++;
      if (obs_pulse[i] !== 1'b1 || obs_phase[i] !== NB_PHASE'(i)) begin
        errors++; $display("FAIL %s_phase_start%0d: ber_clear=%b phase=%0d want 1 %0d", name, i, obs_pulse[i], obs_phase[i], i);
      end
    end
    exp_sweeps = (exp_sweeps < 255) ? exp_sweeps + 1 : 255;
    exp_best   = best;
    checks++;
    if (o_sweep_count !== 8'(exp_sweeps)) begin
      errors++; $display("FAIL %s_sweep_count: got %0d want %0d", name, o_sweep_count, exp_sweeps);
    end
    checks++;
    if (o_best_errors !== NB_COUNT'(exp_best)) begin
      errors++; $display("FAIL %s_best_errors: got %0d want %0d", name, o_best_errors, exp_best);
    end
    checks++;
    if (o_ber_clear !== 1'b1 || o_phase !== NB_PHASE'(lock ? bphase : 0) || o_locked !== 1'b0) begin
      errors++; $display("FAIL %s_after_sweep: ber_clear=%b phase=%0d locked=%b want 1 %0d 0",
                         name, o_ber_clear, o_phase, o_locked, lock ? bphase : 0);
    end
    if (lock) begin
      settle_phase();
      lock_phase = bphase;
      checks++;
      if (o_locked !== 1'b1 || o_phase !== NB_PHASE'(bphase)) begin
        errors++; $display("FAIL %s_lock: locked=%b phase=%0d want 1 %0d", name, o_locked, o_phase, bphase);
      end
    end
    $display("sweep %s errors {%0d,%0d,%0d,%0d}: best %0d phase %0d lock %0d",
             name, errs[0], errs[1], errs[2], errs[3], best, bphase, lock);
    locked_out = lock;
  endtask

  // Back-to-back windows at or under the limit keep the lock.
  task automatic test_locked_keep();
    int n;
    for (int w = 0; w < 3; w++) begin
      n = (w == 0) ? MAX_ERRORS : int'($urandom_range(MAX_ERRORS, 0));
      send_window(n);
      next_cycle();
      checks++;
      if (o_locked !== 1'b1 || o_ber_clear !== 1'b0 || o_phase !== NB_PHASE'(lock_phase)) begin
        errors++; $display("FAIL keep_window%0d: locked=%b ber_clear=%b phase=%0d want 1 0 %0d",
                           w, o_locked, o_ber_clear, o_phase, lock_phase);
      end
      $display("locked window %0d errors %0d: still locked on phase %0d", w, n, lock_phase);
    end
    idle_bits();
  endtask

  // A window over the limit drops the lock and starts a new sweep.
  task automatic test_unlock();
    send_window(MAX_ERRORS + 1);
    next_cycle();
    idle_bits();
    checks++;
    if (o_locked !== 1'b0 || o_phase !== '0 || o_ber_clear !== 1'b1 || o_tx_enable !== 1'b1) begin
      errors++; $display("FAIL unlock: locked=%b phase=%0d ber_clear=%b tx=%b want 0 0 1 1",
                         o_locked, o_phase, o_ber_clear, o_tx_enable);
    end
    checks++;
    if (o_best_errors !== NB_COUNT'(exp_best)) begin
      errors++; $display("FAIL unlock_best_hold: got %0d want %0d", o_best_errors, exp_best);
    end
    $display("locked window errors %0d: lock dropped, resweep", MAX_ERRORS + 1);
  endtask

  task automatic test_random_sweeps();
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < OS; i++) pat[i] = int'($urandom_range(6, 0));
      test_sweep("random", pat, was_locked);
      if (was_locked) test_unlock();
    end
  endtask

  // Stop in the middle of phase-1 measurement while start is held high.
  task automatic test_stop();
    settle_phase();
    send_window(int'($urandom_range(5, 0)));
    next_cycle();
    idle_bits();
    next_cycle();
    checks++;
    if (o_phase !== NB_PHASE'(1) || o_ber_clear !== 1'b1) begin
      errors++; $display("FAIL stop_phase1_start: phase=%0d ber_clear=%b want 1 1", o_phase, o_ber_clear);
    end
    settle_phase();
    for (int k = 0; k < 5; k++) begin
      i_bit_valid = 1'b1;
      i_bit_error = 1'($urandom_range(1, 0));
      next_cycle();
    end
    i_stop  = 1'b1;
    i_start = 1'b1;
    next_cycle();
    idle_bits();
    checks++;
    if (o_tx_enable !== 1'b0 || o_rx_enable !== 1'b0 || o_locked !== 1'b0) begin
      errors++; $display("FAIL stop_disable: tx=%b rx=%b locked=%b want 0 0 0", o_tx_enable, o_rx_enable, o_locked);
    end
    checks++;
    if (o_phase !== NB_PHASE'(1) || o_best_errors !== NB_COUNT'(exp_best) || o_sweep_count !== 8'(exp_sweeps)) begin
      errors++; $display("FAIL stop_hold: phase=%0d best=%0d sweeps=%0d want 1 %0d %0d",
                         o_phase, o_best_errors, o_sweep_count, exp_best, exp_sweeps);
    end
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      checks++;
      if (o_tx_enable !== 1'b0 || o_ber_clear !== 1'b0) begin
        errors++; $display("FAIL stop_held%0d: tx=%b ber_clear=%b want 0 0", k, o_tx_enable, o_ber_clear);
      end
    end
    i_stop = 1'b0;
    next_cycle();
    i_start = 1'b0;
    checks++;
    if (o_ber_clear !== 1'b1 || o_tx_enable !== 1'b1 || o_phase !== '0) begin
      errors++; $display("FAIL stop_release: ber_clear=%b tx=%b phase=%0d want 1 1 0", o_ber_clear, o_tx_enable, o_phase);
    end
    $display("stop during phase 1 measure: idle until stop released, new sweep started");
    pat = '{1, 0, 2, 0};
    test_sweep("after_stop", pat, was_locked);
  endtask

  // Sweep counter sticks at 255 through repeated failing sweeps.
  task automatic test_saturation();
    int n;
    test_unlock();
    pat = '{3, 3, 3, 3};
    n = 256 - exp_sweeps + 1;
    for (int s = 0; s < n; s++) begin
      sweep_phases(pat);
      exp_sweeps = (exp_sweeps < 255) ? exp_sweeps + 1 : 255;
      $display("saturation sweep %0d: sweep_count %0d", s, o_sweep_count);
    end
    exp_best = 3;
    checks++;
    if (o_sweep_count !== 8'(exp_sweeps)) begin
      errors++; $display("FAIL sweep_saturate: got %0d want %0d", o_sweep_count, exp_sweeps);
    end
    checks++;
    if (o_best_errors !== NB_COUNT'(exp_best) || o_locked !== 1'b0 || o_phase !== '0) begin
      errors++; $display("FAIL saturate_state: best=%0d locked=%b phase=%0d want 3 0 0", o_best_errors, o_locked, o_phase);
    end
  endtask

  initial begin
    test_reset();
    start_sweep();
    pat = '{0, 0, 0, 0};
    test_sweep("clean", pat, was_locked);
    test_locked_keep();
    test_unlock();
    pat = '{9, 3, 1, 5};
    test_sweep("best_p2", pat, was_locked);
    test_locked_keep();
    test_unlock();
    pat = '{4, 2, 2, 8};
    test_sweep("tie", pat, was_locked);
    test_unlock();
    pat = '{3, 3, 3, 3};
    test_sweep("no_lock", pat, was_locked);
    test_random_sweeps();
    test_stop();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
